ram_inorder_drain_ctrl: RTL and testbench

- Sequencer for the leaf-interface valid-tagged RAM: one write port (A) carrying data plus a valid bit, one read/clear port (B) with 1-cycle registered read of {valid, data}.
- Accepts packets carrying a slot index and writes them through port A in any order.
- Drains slots through port B strictly in index order onto a valid/ready stream, clearing each slot's valid bit as it is consumed.
- Sits between the leaf packet receiver and the operator's input stream; acts as a reorder buffer.

---
 rtl/ram_inorder_drain_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ram_inorder_drain_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_inorder_drain_ctrl.sv
// -----------------------------------------------------------------------------
// ram_inorder_drain_ctrl
//
// Reorder-buffer sequencer in front of a dual-port, valid-tagged RAM.
// Packets arrive with a slot index in any order and are written through
// port A with the valid bit set. Slots are drained through port B strictly in
// index order onto a valid/ready stream. Each slot's valid bit is cleared
// as the slot is consumed.
//
// Ports
//   clk, reset        sole clock; synchronous active-high reset
//   flush             one-cycle pulse, re-initialises the buffer
//   in_*              input packet stream (data, slot index, valid/ready)
//   out_*             in-order output stream (data, valid/ready)
//   ram_wea/addra/dina   port A write: {valid=1, payload}
//   ram_web/addrb/dinb   port B read address plus valid-bit clear (dinb = 0)
//   ram_doutb         registered read of ram_addrb from the previous cycle
//   occupancy         number of filled, not yet drained slots
//   drained_cnt       packets moved into the output register; wraps
// -----------------------------------------------------------------------------
module ram_inorder_drain_ctrl #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_ADDR_BITS = 7,
    parameter int CNT_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [PAYLOAD_BITS-1:0]  in_data,
    input  logic [NUM_ADDR_BITS-1:0] in_addr,
    input  logic                     in_vld,
    output logic                     in_rdy,
    output logic [PAYLOAD_BITS-1:0]  out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     ram_wea,
    output logic [NUM_ADDR_BITS-1:0] ram_addra,
    output logic [PAYLOAD_BITS:0]    ram_dina,
    output logic                     ram_web,
    output logic [NUM_ADDR_BITS-1:0] ram_addrb,
    output logic [PAYLOAD_BITS:0]    ram_dinb,
    input  logic [PAYLOAD_BITS:0]    ram_doutb,
    output logic [NUM_ADDR_BITS:0]   occupancy,
    output logic [CNT_BITS-1:0]      drained_cnt
);

    localparam logic [NUM_ADDR_BITS-1:0] LAST_IDX  = '1;
    localparam logic [NUM_ADDR_BITS:0]   DEPTH_CNT = {1'b1, {NUM_ADDR_BITS{1'b0}}};

    typedef enum logic [1:0] {
        INIT,   // sweep every slot, clearing its valid bit
        PROBE,  // address rd_ptr; read data not yet available
        CHECK   // inspect ram_doutb for slot rd_ptr
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [NUM_ADDR_BITS-1:0] init_idx;
    logic [NUM_ADDR_BITS-1:0] rd_ptr;
    logic                     free;
    logic                     load;

    // ---------------------------------------------------------------------
    // Write path: purely combinational pass-through to port A.
    // ---------------------------------------------------------------------
    assign in_rdy    = (state != INIT);
    assign ram_wea   = in_vld & in_rdy;
    assign ram_addra = in_addr;
    assign ram_dina  = {1'b1, in_data};
    assign ram_dinb  = '0;

    // Output register can take a new packet when empty or being consumed now.
    assign free = !out_vld || out_rdy;

    // ---------------------------------------------------------------------
    // Next-state and port B control.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_nxt = state;
        ram_web   = 1'b0;
        ram_addrb = rd_ptr;
        load      = 1'b0;

        unique case (state)
            INIT: begin
                ram_web   = 1'b1;
                ram_addrb = init_idx;
                if (init_idx == LAST_IDX) begin
                    state_nxt = PROBE;
                end
            end
            PROBE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                // A load in the flush cycle would be lost anyway; suppressing
                // it keeps drained_cnt equal to packets actually presented.
                if (ram_doutb[PAYLOAD_BITS] && free && !flush) begin
                    load      = 1'b1;
                    ram_web   = 1'b1;
                    state_nxt = PROBE;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        if (flush) begin
            state_nxt = INIT;
        end
    end

    // ---------------------------------------------------------------------
    // State register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values, independent of block ordering.
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers.
    // NOTE: the RAM itself has no reset; its valid bits are cleared by the
    // INIT sweep, which is why both reset and flush land in INIT.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx    <= '0;
            rd_ptr      <= '0;
            out_vld     <= 1'b0;
            out_data    <= '0;
            occupancy   <= '0;
            drained_cnt <= '0;
        end else if (flush) begin
            init_idx  <= '0;
            rd_ptr    <= '0;
            out_vld   <= 1'b0;
            occupancy <= '0;
        end else begin
            // init_idx wraps back to 0 as the sweep finishes.
            if (state == INIT) begin
                init_idx <= init_idx + 1'b1;
            end

            if (state == INIT && init_idx == LAST_IDX) begin
                rd_ptr <= '0;
            end else if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // A load wins over the handshake so a simultaneous consume and
            // refill keeps out_vld high with the new payload.
            if (load) begin
                out_data    <= ram_doutb[PAYLOAD_BITS-1:0];
                out_vld     <= 1'b1;
                drained_cnt <= drained_cnt + 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end

            unique case ({ram_wea, load})
                2'b10: if (occupancy != DEPTH_CNT) occupancy <= occupancy + 1'b1;
                2'b01: if (occupancy != '0)        occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_inorder_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_inorder_drain_ctrl
//
// Bench for ram_inorder_drain_ctrl. Contains a valid-tagged dual-port RAM
// (port A wins on same-address collisions, read-first on port B, unswept
// slots read back as garbage with the valid bit set) and a slot-level
// reorder-buffer model: a shadow array of filled slots, an expected drain
// pointer and a sweep countdown. Every output handshake must deliver the
// next slot in index order.
// -----------------------------------------------------------------------------
module tb_ram_inorder_drain_ctrl;

    localparam int PB    = 32;
    localparam int AB    = 7;
    localparam int CB    = 16;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [PB-1:0] in_data;
    logic [AB-1:0] in_addr;
    logic          in_vld;
    logic          in_rdy;
    logic [PB-1:0] out_data;
    logic          out_vld;
    logic          out_rdy;
    logic          ram_wea;
    logic [AB-1:0] ram_addra;
    logic [PB:0]   ram_dina;
    logic          ram_web;
    logic [AB-1:0] ram_addrb;
    logic [PB:0]   ram_dinb;
    logic [PB:0]   ram_doutb;
    logic [AB:0]   occupancy;
    logic [CB-1:0] drained_cnt;

    always #5 clk = ~clk;

    ram_inorder_drain_ctrl #(
        .PAYLOAD_BITS (PB),
        .NUM_ADDR_BITS(AB),
        .CNT_BITS     (CB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_web    (ram_web),
        .ram_addrb  (ram_addrb),
        .ram_dinb   (ram_dinb),
        .ram_doutb  (ram_doutb),
        .occupancy  (occupancy),
        .drained_cnt(drained_cnt)
    );

    // ---------------------------------------------------------------------
    // Valid-tagged RAM. Slots never written read back with valid set, so a
    // missing sweep shows up as spurious output.
    // ---------------------------------------------------------------------
    logic [PB:0] mem     [DEPTH];
    bit          touched [DEPTH];

    always @(posedge clk) begin
        ram_doutb <= touched[ram_addrb] ? mem[ram_addrb] : {1'b1, 25'h1BAD0DA, ram_addrb};
        if (ram_web) begin
            mem[ram_addrb]     <= ram_dinb;
            touched[ram_addrb] <= 1'b1;
        end
        if (ram_wea) begin
            mem[ram_addra]     <= ram_dina;
            touched[ram_addra] <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Check bookkeeping.
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------------------------------------------------------------
    // Reorder-buffer model and per-cycle compare (negedge, between edges).
    // Model state always describes the buffer after the most recent posedge;
    // the inputs seen at this negedge are the events of the next posedge.
    // ---------------------------------------------------------------------
    bit            model_ok  = 1'b0;
    bit            mdl_vld   [DEPTH];
    logic [PB-1:0] mdl_data  [DEPTH];
    int            mdl_ptr   = 0;
    int            init_left = 0;
    int            emitted   = 0;
    int            discarded = 0;
    int            hs_count  = 0;
    int            cyc       = 0;
    bit            prev_hold = 1'b0;
    logic [PB-1:0] prev_data;
    logic [PB-1:0] rx_q      [$];
    int            hs_cyc    [$];
    int            filled;

    always @(negedge clk) begin
        cyc++;
        if (model_ok) begin
            filled = 0;
            for (int i = 0; i < DEPTH; i++) filled += int'(mdl_vld[i]);

            check("in_rdy", in_rdy, init_left == 0);
            check("ram_wea", ram_wea, in_vld && init_left == 0);
            check("ram_addra", ram_addra, in_addr);
            check("ram_dina", ram_dina, {1'b1, in_data});
            check("ram_dinb", ram_dinb, 0);
            if (init_left > 0) begin
                check("sweep_web", ram_web, 1);
                check("sweep_addrb", ram_addrb, DEPTH - init_left);
                check("sweep_out_vld", out_vld, 0);
            end
            check("occupancy", occupancy + int'(out_vld), filled);
            check("drained_cnt", drained_cnt, CB'(emitted + discarded + int'(out_vld)));
            if (prev_hold) begin
                check("hold_vld", out_vld, 1);
                check("hold_data", out_data, prev_data);
            end
        end

        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
            mdl_ptr   = 0;
            init_left = DEPTH;
            emitted   = 0;
            discarded = 0;
            prev_hold = 1'b0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            if (out_vld && out_rdy) begin
                check("order_slot_filled", mdl_vld[mdl_ptr], 1);
                check("order_data", out_data, mdl_data[mdl_ptr]);
                mdl_vld[mdl_ptr] = 1'b0;
                mdl_ptr          = (mdl_ptr + 1) % DEPTH;
                emitted++;
                hs_count++;
                rx_q.push_back(out_data);
                hs_cyc.push_back(cyc);
            end
            if (in_vld && init_left == 0) begin
                mdl_vld[in_addr]  = 1'b1;
                mdl_data[in_addr] = in_data;
            end
            prev_hold = out_vld && !out_rdy && !flush;
            prev_data = out_data;
            if (flush) begin
                if (out_vld && !out_rdy) discarded++;
                for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
                mdl_ptr   = 0;
                init_left = DEPTH;
            end else if (init_left > 0) begin
                init_left--;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge).
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [PB-1:0] d);
        int w = 0;
        in_addr = a;
        in_data = d;
        in_vld  = 1'b1;
        while (!in_rdy && w < 500) begin
            tick(1);
            w++;
        end
        check("write_accepted", in_rdy, 1);
        tick(1);
        in_vld = 1'b0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (!in_rdy && n < 1000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_hs(input int target, input string name);
        int w = 0;
        while (hs_count < target && w < 2000) begin
            tick(1);
            w++;
        end
        check(name, hs_count >= target, 1);
    endtask

    task automatic do_flush();
        int n;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        count_init(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Directed tests.
    // ---------------------------------------------------------------------
    initial begin
        int n;
        int base;
        reset   = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_addr = '0;
        in_data = '0;
        out_rdy = 1'b0;
        tick(3);
        reset = 1'b0;

        // Reset values and the power-up sweep.
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_drained", drained_cnt, 0);
        count_init(n);
        check("init_len", n, 128);
        tick(5);
        check("idle_out_vld", out_vld, 0);

        // In-order stream at full rate.
        out_rdy = 1'b1;
        base    = hs_count;
        for (int i = 0; i < 4; i++) do_write(AB'(i), PB'(32'hA0 + i));
        wait_hs(base + 4, "t2_drained");
        for (int i = 0; i < 4; i++) check("t2_data", rx_q[base + i], 32'hA0 + i);
        for (int i = 0; i < 3; i++) check("t2_cadence", hs_cyc[base + i + 1] - hs_cyc[base + i], 2);
        tick(3);
        check("t2_drained_cnt", drained_cnt, 4);
        check("t2_occupancy", occupancy, 0);

        // Out-of-order arrival: nothing leaves until slot 0 shows up.
        do_flush();
        base = hs_count;
        do_write(7'd2, 32'hC2);
        do_write(7'd1, 32'hC1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_no_early", out_vld, 0);
        end
        do_write(7'd0, 32'hC0);
        wait_hs(base + 3, "t3_drained");
        check("t3_d0", rx_q[base], 32'hC0);
        check("t3_d1", rx_q[base + 1], 32'hC1);
        check("t3_d2", rx_q[base + 2], 32'hC2);

        // Backpressure: slot 0 held, slot 1 untouched, pointer parked on 1.
        do_flush();
        out_rdy = 1'b0;
        base    = hs_count;
        do_write(7'd0, 32'hD0);
        do_write(7'd1, 32'hD1);
        tick(8);
        check("t4_vld", out_vld, 1);
        check("t4_data", out_data, 32'hD0);
        check("t4_slot1_valid", mem[1][PB], 1);
        check("t4_ptr", ram_addrb, 1);
        check("t4_no_hs", hs_count, base);
        tick(5);
        check("t4_data_stable", out_data, 32'hD0);
        out_rdy = 1'b1;
        wait_hs(base + 2, "t4_drained");
        check("t4_d0", rx_q[base], 32'hD0);
        check("t4_d1", rx_q[base + 1], 32'hD1);

        // Pointer wrap: walk slots 2..125, then 126, 127, 0.
        base = hs_count;
        for (int a = 2; a < 126; a++) do_write(AB'(a), PB'(32'h1000 + a));
        wait_hs(base + 124, "t5_walk");
        tick(4);
        check("t5_ptr126", ram_addrb, 126);
        base = hs_count;
        do_write(7'd126, 32'hE126);
        do_write(7'd127, 32'hE127);
        do_write(7'd0, 32'hE000);
        wait_hs(base + 3, "t5_drained");
        check("t5_d126", rx_q[base], 32'hE126);
        check("t5_d127", rx_q[base + 1], 32'hE127);
        check("t5_d0", rx_q[base + 2], 32'hE000);
        tick(4);
        check("t5_ptr_wrapped", ram_addrb, 1);

        // Flush mid-drain: remaining slots are swept, never emitted.
        do_flush();
        out_rdy = 1'b0;
        base    = hs_count;
        for (int i = 0; i < 6; i++) do_write(AB'(i), PB'(32'hF0 + i));
        out_rdy = 1'b1;
        wait_hs(base + 2, "t6_two");
        out_rdy = 1'b0;
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t6_out_vld", out_vld, 0);
        check("t6_occupancy", occupancy, 0);
        count_init(n);
        check("t6_sweep_len", n, 128);
        out_rdy = 1'b1;
        tick(20);
        check("t6_no_more", hs_count, base + 2);
        check("t6_idle_vld", out_vld, 0);
        check("t6_ptr", ram_addrb, 0);
        check("t6_d0", rx_q[base], 32'hF0);
        check("t6_d1", rx_q[base + 1], 32'hF1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
